// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: one CPU read/write request becomes one bus request/response transaction.
// Optional misalignment trap is compiled in with `define LSU_MISALIGN_TRAP_EN.
module lsu_bus_bridge #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic              rready_cpu,
  output logic              rvalid_cpu,
  input  logic              wvalid_cpu,
  output logic              wready_cpu,
  input  logic [31:0]       wdata_cpu,
  input  logic [3:0]        strb_cpu,
`ifdef LSU_MISALIGN_TRAP_EN
  input  logic [1:0]        misalign_rd_size,
`endif
  output logic [31:0]       rdata_cpu,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] lsu_err_addr
);

  localparam int unsigned CntW   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit          WdogEn = (TIMEOUT_CYC != 0);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYC == 0) ? '0 : CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StReq, StRsp, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              capture, abort, timeout, misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  // Writes infer access size from the lane-shifted strobes; reads use the supplied size.
  always_comb begin
    misalign = 1'b0;
    if (wvalid_cpu) begin
      case (strb_cpu)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: misalign = 1'b0;
        4'b0011, 4'b1100:                   misalign = addr_cpu[0];
        4'b1111:                            misalign = |addr_cpu[1:0];
        default:                            misalign = 1'b1;
      endcase
    end else begin
      case (misalign_rd_size)
        2'b01:   misalign = addr_cpu[0];
        2'b10:   misalign = |addr_cpu[1:0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign timeout = WdogEn && (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    capture    = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rready_cpu || wvalid_cpu) begin
          addr_d  = addr_cpu;
          we_d    = wvalid_cpu;
          wdata_d = wdata_cpu;
          strb_d  = wvalid_cpu ? strb_cpu : 4'b0000;
          err_d   = 1'b0;
          state_d = StReq;
          if (misalign) begin
            state_d    = StDone;
            err_d      = 1'b1;
            err_addr_d = addr_cpu;
          end
        end
      end
      StReq: begin
        // A handshake on the last watchdog cycle still counts; the bus has seen it.
        if (bus_req_ready) begin
          if (bus_rsp_valid) capture = 1'b1;
          else               state_d = StRsp;
        end else if (timeout) begin
          abort = 1'b1;
        end
      end
      StRsp: begin
        if (bus_rsp_valid) capture = 1'b1;
        else if (timeout)  abort   = 1'b1;
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      state_d = StDone;
      if (!we_q) rdata_d = bus_rsp_err ? 32'h0 : bus_rsp_rdata;
      if (bus_rsp_err) begin
        err_d      = 1'b1;
        err_addr_d = addr_q;
      end
    end
    if (abort) begin
      state_d    = StDone;
      err_d      = 1'b1;
      err_addr_d = addr_q;
      if (!we_q) rdata_d = 32'h0;
    end

    // Watchdog restarts on every state change and saturates rather than wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == StReq || state_q == StRsp) && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_req_valid = (state_q == StReq);
  assign bus_we        = we_q;
  assign bus_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata     = wdata_q;
  assign bus_wstrb     = strb_q;
  // Completion is qualified by the live CPU request so a dropped request finishes silently.
  assign rvalid_cpu    = (state_q == StDone) && !we_q && rready_cpu;
  assign wready_cpu    = (state_q == StDone) && we_q && wvalid_cpu;
  assign rdata_cpu     = rdata_q;
  assign lsu_err       = (state_q == StDone) && err_q;
  assign lsu_err_addr  = err_addr_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Self-checking bench for lsu_bus_bridge: directed scenarios plus randomized bus timing
// checked against a transaction-level latency/result model.
module tb_lsu_bus_bridge;
  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_cpu = '0;
  logic        rready_cpu = 1'b0, wvalid_cpu = 1'b0;
  logic        rvalid_cpu, wready_cpu;
  logic [31:0] wdata_cpu = '0;
  logic [3:0]  strb_cpu = '0;
  logic [31:0] rdata_cpu;
  logic        bus_req_valid, bus_we;
  logic        bus_req_ready = 1'b0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid = 1'b0, bus_rsp_err = 1'b0;
  logic [31:0] bus_rsp_rdata = '0;
  logic        lsu_err;
  logic [31:0] lsu_err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations from the last drive_txn call.
  int          o_comp, o_comp_cyc, o_err, o_req_cyc;
  logic [31:0] o_rdata, o_baddr, o_bwdata;
  logic [3:0]  o_bwstrb;
  logic        o_bwe, o_held, o_stable;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.ADDR_W(32), .TIMEOUT_CYC(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_cpu      (addr_cpu),
    .rready_cpu    (rready_cpu),
    .rvalid_cpu    (rvalid_cpu),
    .wvalid_cpu    (wvalid_cpu),
    .wready_cpu    (wready_cpu),
    .wdata_cpu     (wdata_cpu),
    .strb_cpu      (strb_cpu),
    .rdata_cpu     (rdata_cpu),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_wstrb     (bus_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .lsu_err       (lsu_err),
    .lsu_err_addr  (lsu_err_addr)
  );

  // Expected outcome of one transaction from the bus timing: ready after d_r idle request cycles,
  // response d_s cycles after acceptance (0 = same cycle). Cycles counted from request launch.
  task automatic model(input int d_r, input int d_s, input logic rsp_err, input logic [31:0] rsp_data,
                       output int e_cyc, output int e_req, output int e_err,
                       output logic [31:0] e_rdata);
    bit to;
    to = 0;
    if (d_r >= int'(T)) begin
      to = 1; e_req = T; e_cyc = T + 1;
    end else begin
      e_req = d_r + 1;
      if (d_s > int'(T)) begin
        to = 1; e_cyc = d_r + T + 2;
      end else begin
        e_cyc = d_r + d_s + 2;
      end
    end
    e_err   = (to || rsp_err) ? 1 : 0;
    e_rdata = e_err ? 32'h0 : rsp_data;
  endtask

  task automatic drive_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] rsp_data, input logic rsp_err,
                           input int d_r, input int d_s, input int drop_cyc);
    int acc_cyc;
    int stop;
    o_comp = 0; o_comp_cyc = -1; o_err = 0; o_req_cyc = 0; o_held = 1; o_stable = 1;
    o_rdata = '0; o_baddr = '0; o_bwdata = '0; o_bwstrb = '0; o_bwe = 0;
    acc_cyc = -1; stop = 60;
    addr_cpu = addr; wdata_cpu = wdata; strb_cpu = strb;
    wvalid_cpu = we; rready_cpu = !we;
    for (int cyc = 1; cyc <= stop; cyc++) begin
      @(posedge clk); #1;
      bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_err = 0; bus_rsp_rdata = $urandom;
      if (cyc == drop_cyc) begin
        rready_cpu = 0; wvalid_cpu = 0; stop = cyc + 12;
      end
      if (bus_req_valid) begin
        o_req_cyc++;
        if (o_req_cyc == 1) begin
          o_baddr = bus_addr; o_bwdata = bus_wdata; o_bwstrb = bus_wstrb; o_bwe = bus_we;
        end else if (bus_addr !== o_baddr || bus_wdata !== o_bwdata || bus_wstrb !== o_bwstrb ||
                     bus_we !== o_bwe) begin
          o_stable = 0;
        end
        if (o_req_cyc == d_r + 1) begin
          bus_req_ready = 1; acc_cyc = cyc;
        end
      end
      if (acc_cyc >= 0 && cyc == acc_cyc + d_s) begin
        bus_rsp_valid = 1; bus_rsp_rdata = rsp_data; bus_rsp_err = rsp_err;
      end
      #1;
      if (lsu_err === 1'b1) o_err++;
      if (rvalid_cpu === 1'b1 || wready_cpu === 1'b1) begin
        o_comp++;
        if (o_comp == 1) begin
          o_comp_cyc = cyc; o_rdata = rdata_cpu; stop = cyc + 2;
        end
        rready_cpu = 0; wvalid_cpu = 0;
      end else if (o_comp_cyc > 0 && rdata_cpu !== o_rdata) begin
        o_held = 0;
      end
    end
    rready_cpu = 0; wvalid_cpu = 0; bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({rvalid_cpu, wready_cpu, bus_req_valid, lsu_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {rvalid_cpu, wready_cpu, bus_req_valid, lsu_err});
    end
    n_cmp++; if (rdata_cpu !== 32'h0 || lsu_err_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got rdata %h err_addr %h want 0 0", rdata_cpu, lsu_err_addr);
    end
    n_cmp++; if (bus_addr !== 32'h0 || bus_wstrb !== 4'h0 || bus_we !== 1'b0) begin
      n_bad++; $display("FAIL reset_bus: got addr %h strb %h we %b want 0", bus_addr, bus_wstrb, bus_we);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_zero_wait();
    drive_txn(1'b0, 32'h104, 32'h0, 4'h0, 32'hA5A5_1234, 1'b0, 0, 1, 0);
    n_cmp++; if (o_baddr !== 32'h104 || o_bwe !== 1'b0 || o_bwstrb !== 4'h0) begin
      n_bad++; $display("FAIL rd_bus_fields: got addr %h we %b strb %h want 104 0 0", o_baddr, o_bwe, o_bwstrb);
    end
    n_cmp++; if (o_comp !== 1 || o_comp_cyc !== 3) begin
      n_bad++; $display("FAIL rd_latency: got %0d pulses at cycle %0d want 1 at 3", o_comp, o_comp_cyc);
    end
    n_cmp++; if (o_rdata !== 32'hA5A5_1234) begin
      n_bad++; $display("FAIL rd_data: got %h want a5a51234", o_rdata);
    end
    n_cmp++; if (o_held !== 1'b1) begin
      n_bad++; $display("FAIL rd_hold: got held=%b want 1", o_held);
    end
  endtask

  task automatic test_sb_write();
    drive_txn(1'b1, 32'h203, 32'h7700_0000, 4'b1000, 32'h0, 1'b0, 0, 1, 0);
    n_cmp++; if (o_baddr !== 32'h200 || o_bwstrb !== 4'b1000 || o_bwe !== 1'b1) begin
      n_bad++; $display("FAIL sb_bus_fields: got addr %h strb %b we %b want 200 1000 1", o_baddr, o_bwstrb, o_bwe);
    end
    n_cmp++; if (o_bwdata !== 32'h7700_0000) begin
      n_bad++; $display("FAIL sb_wdata: got %h want 77000000", o_bwdata);
    end
    n_cmp++; if (o_comp !== 1 || o_err !== 0) begin
      n_bad++; $display("FAIL sb_complete: got %0d pulses %0d errs want 1 0", o_comp, o_err);
    end
  endtask

  task automatic test_backpressure();
    int e_cyc, e_req, e_err; logic [31:0] e_rd;
    model(5, 3, 1'b0, 32'h1357_9BDF, e_cyc, e_req, e_err, e_rd);
    drive_txn(1'b0, 32'h0000_0ABC, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 5, 3, 0);
    n_cmp++; if (o_stable !== 1'b1 || o_req_cyc !== e_req) begin
      n_bad++; $display("FAIL bp_req: got stable=%b req_cycles=%0d want 1 %0d", o_stable, o_req_cyc, e_req);
    end
    n_cmp++; if (o_comp !== 1 || o_comp_cyc !== e_cyc || o_rdata !== e_rd) begin
      n_bad++; $display("FAIL bp_done: got %0d@%0d data %h want 1@%0d %h", o_comp, o_comp_cyc, o_rdata, e_cyc, e_rd);
    end
  endtask

  task automatic test_timeout();
    drive_txn(1'b0, 32'h1234_5678, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 100, 1, 0);
    n_cmp++; if (o_req_cyc !== int'(T)) begin
      n_bad++; $display("FAIL to_req_cycles: got %0d want %0d", o_req_cyc, T);
    end
    n_cmp++; if (o_comp !== 1 || o_comp_cyc !== int'(T) + 1 || o_rdata !== 32'h0) begin
      n_bad++; $display("FAIL to_done: got %0d@%0d data %h want 1@%0d 0", o_comp, o_comp_cyc, o_rdata, T + 1);
    end
    n_cmp++; if (o_err !== 1 || lsu_err_addr !== 32'h1234_5678) begin
      n_bad++; $display("FAIL to_err: got %0d pulses addr %h want 1 12345678", o_err, lsu_err_addr);
    end
  endtask

  task automatic test_rsp_err();
    drive_txn(1'b1, 32'h8000_0000, 32'hCAFE_0001, 4'b1111, 32'h0, 1'b1, 0, 1, 0);
    n_cmp++; if (o_comp !== 1 || o_err !== 1) begin
      n_bad++; $display("FAIL err_pulses: got %0d done %0d err want 1 1", o_comp, o_err);
    end
    n_cmp++; if (lsu_err_addr !== 32'h8000_0000) begin
      n_bad++; $display("FAIL err_addr: got %h want 80000000", lsu_err_addr);
    end
  endtask

  task automatic test_dropped_request();
    drive_txn(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'h2468_ACE0, 1'b0, 0, 4, 2);
    n_cmp++; if (o_comp !== 0 || o_err !== 0) begin
      n_bad++; $display("FAIL drop_silent: got %0d pulses %0d errs want 0 0", o_comp, o_err);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    drive_txn(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 0, 1, 0);
    addr_cpu = 32'h40; rready_cpu = 1;
    @(posedge clk); #1;
    bus_req_ready = 1;
    @(posedge clk); #1;
    bus_req_ready = 0; rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; rready_cpu = 0;
    n_cmp++; if (rdata_cpu !== 32'h0 || lsu_err_addr !== 32'h0 || bus_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got rdata %h err_addr %h req %b want 0 0 0", rdata_cpu, lsu_err_addr, bus_req_valid);
    end
    bus_rsp_valid = 1; bus_rsp_rdata = 32'h1111_2222;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_rsp_valid = 0;
      if (rvalid_cpu !== 1'b0 || lsu_err !== 1'b0 || rdata_cpu !== 32'h0 || bus_req_valid !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin
      n_bad++; $display("FAIL late_rsp: got %0d disturbed cycles want 0", bad);
    end
    drive_txn(1'b0, 32'h300, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 0, 1, 0);
    n_cmp++; if (o_comp !== 1 || o_comp_cyc !== 3 || o_rdata !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL post_reset_rd: got %0d@%0d data %h want 1@3 0badf00d", o_comp, o_comp_cyc, o_rdata);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic we, rerr; logic [31:0] addr, wd, rd, e_rd; logic [3:0] strb;
      int d_r, d_s, e_cyc, e_req, e_err;
      we = 1'($urandom_range(0, 1)); addr = $urandom; wd = $urandom; rd = $urandom;
      strb = 4'($urandom_range(1, 15)); rerr = ($urandom_range(0, 7) == 0);
      d_r = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 2);
      d_s = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 11) : $urandom_range(0, 2);
      model(d_r, d_s, rerr, rd, e_cyc, e_req, e_err, e_rd);
      drive_txn(we, addr, wd, strb, rd, rerr, d_r, d_s, 0);
      n_cmp++; if (o_baddr !== {addr[31:2], 2'b00} || o_bwe !== we || o_bwstrb !== (we ? strb : 4'h0) || o_stable !== 1'b1) begin
        n_bad++; $display("FAIL rnd%0d_fields: got addr %h we %b strb %h stable %b want %h %b %h 1", n, o_baddr, o_bwe, o_bwstrb, o_stable, {addr[31:2], 2'b00}, we, we ? strb : 4'h0);
      end
      n_cmp++; if (o_comp !== 1 || o_comp_cyc !== e_cyc || o_req_cyc !== e_req) begin
        n_bad++; $display("FAIL rnd%0d_timing: got %0d@%0d req %0d want 1@%0d req %0d (d_r %0d d_s %0d)", n, o_comp, o_comp_cyc, o_req_cyc, e_cyc, e_req, d_r, d_s);
      end
      n_cmp++; if (o_err !== e_err || (e_err == 1 && lsu_err_addr !== addr)) begin
        n_bad++; $display("FAIL rnd%0d_err: got %0d addr %h want %0d %h", n, o_err, lsu_err_addr, e_err, addr);
      end
      if (!we) begin
        n_cmp++; if (o_rdata !== e_rd || o_held !== 1'b1) begin
          n_bad++; $display("FAIL rnd%0d_rdata: got %h held %b want %h 1", n, o_rdata, o_held, e_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_sb_write();
    test_backpressure();
    test_timeout();
    test_rsp_err();
    test_dropped_request();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
